mem_lsu: RTL and testbench

Load/store stage directly downstream of ex. It consumes ex's result (rd address, rd data, write enable) plus memory-op qualifiers, and either forwards ALU results or executes loads and stores over a simple request/response data bus. It presents a registered write-back (rd_addr, rd_data, rd_wen) to regs. It asserts hold_o to freeze id_ex/if_id/pc_reg while a bus transaction is outstanding.

---
 rtl/rv_defs_pkg.sv | 43 ++++
 rtl/lsu_load_align.sv | 35 +++
 rtl/mem_lsu.sv | 179 +++++++++++++++++
 tb/tb_mem_lsu.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_defs_pkg.sv
// Shared RV32 load/store definitions: funct3 encodings, LSU state encoding
// and the alignment/legality rule for memory accesses.
package rv_defs_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // True when funct3 is a defined encoding and addr_lo is naturally aligned for its size.
    function automatic logic mem_access_ok(input logic is_load, input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        if (is_load) begin
            case (funct3)
                F3_LB, F3_LBU: ok = 1'b1;
                F3_LH, F3_LHU: ok = ~addr_lo[0];
                F3_LW:         ok = (addr_lo == 2'b00);
                default:       ok = 1'b0;
            endcase
        end else begin
            case (funct3)
                F3_SB:   ok = 1'b1;
                F3_SH:   ok = ~addr_lo[0];
                F3_SW:   ok = (addr_lo == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a bus read word and sign/zero extends it.
module lsu_load_align
    import rv_defs_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    localparam int LANES = XLEN / 8;

    logic [7:0]  lanes [LANES];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lanes[gi] = rdata[8*gi +: 8];
    end

    always_comb begin
        byte_sel = lanes[addr_lo];
        half_sel = addr_lo[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store stage: forwards ALU results or runs one bus transaction per memory op,
// stalling the front of the pipeline while a transaction is outstanding.
module mem_lsu
    import rv_defs_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   sdata_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [XLEN-1:0]   rd_data_i,
    input  logic              rd_wen_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [XLEN-1:0]   bus_wdata_o,
    output logic [3:0]        bus_wstrb_o,
    input  logic              bus_ready_i,
    input  logic              bus_rvalid_i,
    input  logic [XLEN-1:0]   bus_rdata_i,
    output logic [4:0]        wb_rd_addr_o,
    output logic [XLEN-1:0]   wb_rd_data_o,
    output logic              wb_rd_wen_o,
    output logic              hold_o,
    output logic              err_o
);

    lsu_state_e        state_reg, state_next;
    logic              bus_req_reg, bus_req_next;
    logic              bus_we_reg, bus_we_next;
    logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
    logic [XLEN-1:0]   bus_wdata_reg, bus_wdata_next;
    logic [3:0]        bus_wstrb_reg, bus_wstrb_next;
    logic [4:0]        wb_addr_reg, wb_addr_next;
    logic [XLEN-1:0]   wb_data_reg, wb_data_next;
    logic              wb_wen_reg, wb_wen_next;
    logic              err_reg, err_next;
    logic [4:0]        ld_rd_reg, ld_rd_next;
    logic [2:0]        ld_f3_reg, ld_f3_next;
    logic [1:0]        ld_lo_reg, ld_lo_next;

    logic [XLEN-1:0]   st_wdata;
    logic [3:0]        st_wstrb;
    logic [XLEN-1:0]   load_data;

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .rdata   (bus_rdata_i),
        .addr_lo (ld_lo_reg),
        .funct3  (ld_f3_reg),
        .data    (load_data)
    );

    // Store data is replicated across lanes so the slave can use the strobes alone.
    always_comb begin
        case (funct3_i)
            F3_SB: begin
                st_wdata = {4{sdata_i[7:0]}};
                st_wstrb = 4'b0001 << addr_i[1:0];
            end
            F3_SH: begin
                st_wdata = {2{sdata_i[15:0]}};
                st_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = sdata_i;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        bus_req_next   = bus_req_reg;
        bus_we_next    = bus_we_reg;
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        bus_wstrb_next = bus_wstrb_reg;
        wb_addr_next   = wb_addr_reg;
        wb_data_next   = wb_data_reg;
        wb_wen_next    = 1'b0;
        err_next       = 1'b0;
        ld_rd_next     = ld_rd_reg;
        ld_f3_next     = ld_f3_reg;
        ld_lo_next     = ld_lo_reg;
        case (state_reg)
            IDLE: begin
                if (op_valid_i) begin
                    if (is_load_i || is_store_i) begin
                        if (!mem_access_ok(is_load_i, funct3_i, addr_i[1:0])) begin
                            err_next = 1'b1;
                        end else begin
                            state_next     = REQ;
                            bus_req_next   = 1'b1;
                            bus_we_next    = ~is_load_i;
                            bus_addr_next  = {addr_i[ADDR_W-1:2], 2'b00};
                            bus_wdata_next = is_load_i ? '0 : st_wdata;
                            bus_wstrb_next = is_load_i ? 4'b0000 : st_wstrb;
                            ld_rd_next     = rd_addr_i;
                            ld_f3_next     = funct3_i;
                            ld_lo_next     = addr_i[1:0];
                        end
                    end else begin
                        wb_wen_next  = rd_wen_i && (rd_addr_i != 5'd0);
                        wb_addr_next = rd_addr_i;
                        wb_data_next = rd_data_i;
                    end
                end
            end
            REQ: begin
                if (bus_ready_i) begin
                    bus_req_next   = 1'b0;
                    bus_we_next    = 1'b0;
                    bus_wstrb_next = 4'b0000;
                    state_next     = bus_we_reg ? IDLE : RESP;
                end
            end
            RESP: begin
                if (bus_rvalid_i) begin
                    state_next   = IDLE;
                    wb_wen_next  = (ld_rd_reg != 5'd0);
                    wb_addr_next = ld_rd_reg;
                    wb_data_next = load_data;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            bus_wstrb_reg <= 4'b0000;
            wb_addr_reg   <= 5'd0;
            wb_data_reg   <= '0;
            wb_wen_reg    <= 1'b0;
            err_reg       <= 1'b0;
            ld_rd_reg     <= 5'd0;
            ld_f3_reg     <= 3'd0;
            ld_lo_reg     <= 2'd0;
        end else begin
            state_reg     <= state_next;
            bus_req_reg   <= bus_req_next;
            bus_we_reg    <= bus_we_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            bus_wstrb_reg <= bus_wstrb_next;
            wb_addr_reg   <= wb_addr_next;
            wb_data_reg   <= wb_data_next;
            wb_wen_reg    <= wb_wen_next;
            err_reg       <= err_next;
            ld_rd_reg     <= ld_rd_next;
            ld_f3_reg     <= ld_f3_next;
            ld_lo_reg     <= ld_lo_next;
        end
    end

    assign bus_req_o    = bus_req_reg;
    assign bus_we_o     = bus_we_reg;
    assign bus_addr_o   = bus_addr_reg;
    assign bus_wdata_o  = bus_wdata_reg;
    assign bus_wstrb_o  = bus_wstrb_reg;
    assign wb_rd_addr_o = wb_addr_reg;
    assign wb_rd_data_o = wb_data_reg;
    assign wb_rd_wen_o  = wb_wen_reg;
    assign err_o        = err_reg;
    assign hold_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed and randomized ALU, load and store traffic
// compared against a byte-level reference model of RV32 load/store semantics.
module tb_mem_lsu;

    localparam int ADDR_W = 32;
    localparam int XLEN   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              op_valid = 1'b0;
    logic              is_load = 1'b0;
    logic              is_store = 1'b0;
    logic [2:0]        funct3 = 3'd0;
    logic [ADDR_W-1:0] addr = '0;
    logic [XLEN-1:0]   sdata = '0;
    logic [4:0]        rd_addr = 5'd0;
    logic [XLEN-1:0]   rd_data = '0;
    logic              rd_wen = 1'b0;
    logic              bus_req, bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [XLEN-1:0]   bus_wdata;
    logic [3:0]        bus_wstrb;
    logic              bus_ready = 1'b0;
    logic              bus_rvalid = 1'b0;
    logic [XLEN-1:0]   bus_rdata = '0;
    logic [4:0]        wb_rd_addr;
    logic [XLEN-1:0]   wb_rd_data;
    logic              wb_rd_wen;
    logic              hold;
    logic              err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid_i   (op_valid),
        .is_load_i    (is_load),
        .is_store_i   (is_store),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .sdata_i      (sdata),
        .rd_addr_i    (rd_addr),
        .rd_data_i    (rd_data),
        .rd_wen_i     (rd_wen),
        .bus_req_o    (bus_req),
        .bus_we_o     (bus_we),
        .bus_addr_o   (bus_addr),
        .bus_wdata_o  (bus_wdata),
        .bus_wstrb_o  (bus_wstrb),
        .bus_ready_i  (bus_ready),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata),
        .wb_rd_addr_o (wb_rd_addr),
        .wb_rd_data_o (wb_rd_data),
        .wb_rd_wen_o  (wb_rd_wen),
        .hold_o       (hold),
        .err_o        (err)
    );

    // ---------------- reference model ----------------
    function automatic int op_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ref_legal(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        bit f3_ok;
        if (ld) f3_ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else    f3_ok = (f3 <= 3'd2);
        return f3_ok && ((a % op_bytes(f3)) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [2:0] f3);
        logic [31:0] v;
        v = word >> ((a % 4) * 8);
        case (f3)
            3'd0:    return 32'($signed(v[7:0]));
            3'd1:    return 32'($signed(v[15:0]));
            3'd4:    return v & 32'h0000_00FF;
            3'd5:    return v & 32'h0000_FFFF;
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int mask;
        mask = ((1 << op_bytes(f3)) - 1) << (a % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] r;
        int nb;
        nb = op_bytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % nb) +: 8];
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_op();
        op_valid = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
    endtask

    // Runs one memory op to completion with the given wait states, checking every cycle.
    task automatic run_mem_op(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [4:0] rd,
                              input logic [31:0] word, input int waits, input int rv_delay);
        logic [31:0] exp_addr, exp_wdata, exp_data;
        logic [3:0]  exp_wstrb;
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_wdata = ld ? 32'd0 : ref_wdata(f3, sd);
        exp_wstrb = ld ? 4'd0 : ref_wstrb(f3, a);
        exp_data  = ref_load(word, a, f3);
        op_valid = 1'b1; is_load = ld; is_store = ~ld; funct3 = f3; addr = a;
        sdata = sd; rd_addr = rd; rd_data = $urandom; rd_wen = 1'b1;
        tick();
        clear_op();
        if (!ref_legal(ld, f3, a)) begin
            $display("txn %s f3=%0d addr=%08h -> error expected", ld ? "load" : "store", f3, a);
            checks++;
            if ({err, bus_req, wb_rd_wen, hold} !== 4'b1000) begin
                errors++;
                $display("FAIL bad_access: err/req/wen/hold=%b want 1000", {err, bus_req, wb_rd_wen, hold});
            end
            tick();
            checks++;
            if ({err, bus_req, hold} !== 3'b000) begin
                errors++;
                $display("FAIL err_pulse: err/req/hold=%b want 000", {err, bus_req, hold});
            end
            return;
        end
        $display("txn %s f3=%0d addr=%08h sd=%08h rd=%0d word=%08h waits=%0d", ld ? "load" : "store",
                 f3, a, sd, rd, word, waits);
        for (int w = 0; w <= waits; w++) begin
            checks++;
            if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, hold, err} !==
                {1'b1, ~ld, exp_addr, exp_wdata, exp_wstrb, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL req_fields: req=%b we=%b addr=%08h wdata=%08h wstrb=%b hold=%b want we=%b addr=%08h wdata=%08h wstrb=%b hold=1",
                         bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, hold, ~ld, exp_addr, exp_wdata, exp_wstrb);
            end
            if (w == waits) begin
                bus_ready = 1'b1;
            end else begin
                bus_rvalid = 1'b1;
                bus_rdata  = $urandom;
            end
            tick();
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
        end
        if (!ld) begin
            checks++;
            if ({bus_req, hold, wb_rd_wen} !== 3'b000) begin
                errors++;
                $display("FAIL store_done: req/hold/wen=%b want 000", {bus_req, hold, wb_rd_wen});
            end
            return;
        end
        for (int w = 0; w < rv_delay; w++) begin
            checks++;
            if ({bus_req, hold, wb_rd_wen} !== 3'b010) begin
                errors++;
                $display("FAIL resp_wait: req/hold/wen=%b want 010", {bus_req, hold, wb_rd_wen});
            end
            tick();
        end
        bus_rvalid = 1'b1;
        bus_rdata  = word;
        tick();
        bus_rvalid = 1'b0;
        checks++;
        if ({hold, wb_rd_wen} !== {1'b0, rd != 5'd0}) begin
            errors++;
            $display("FAIL load_wen: hold/wen=%b want %b", {hold, wb_rd_wen}, {1'b0, rd != 5'd0});
        end
        if (rd != 5'd0) begin
            checks++;
            if ({wb_rd_addr, wb_rd_data} !== {rd, exp_data}) begin
                errors++;
                $display("FAIL load_data: rd=%0d data=%08h want rd=%0d data=%08h", wb_rd_addr, wb_rd_data, rd, exp_data);
            end
        end
        tick();
        checks++;
        if (wb_rd_wen !== 1'b0) begin
            errors++;
            $display("FAIL wen_pulse: wen=%b want 0", wb_rd_wen);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        op_valid = 1'b1; rd_addr = 5'd4; rd_data = 32'hDEAD_BEEF; rd_wen = 1'b1;
        tick();
        tick();
        clear_op();
        $display("txn reset");
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_bus: req=%b we=%b addr=%08h wdata=%08h wstrb=%b want all 0",
                     bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb);
        end
        checks++;
        if ({wb_rd_addr, wb_rd_data, wb_rd_wen, hold, err} !== '0) begin
            errors++;
            $display("FAIL reset_wb: addr=%0d data=%08h wen=%b hold=%b err=%b want all 0",
                     wb_rd_addr, wb_rd_data, wb_rd_wen, hold, err);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        logic [4:0]  rd;
        logic [31:0] d;
        logic        we;
        for (int i = 0; i < 12; i++) begin
            rd = (i == 0) ? 5'd5 : (i == 1) ? 5'd0 : 5'($urandom);
            d  = (i == 0) ? 32'h1234 : $urandom;
            we = (i == 0) ? 1'b1 : 1'($urandom);
            op_valid = 1'b1; is_load = 1'b0; is_store = 1'b0; funct3 = 3'($urandom);
            addr = $urandom; rd_addr = rd; rd_data = d; rd_wen = we;
            tick();
            clear_op();
            $display("txn alu rd=%0d data=%08h wen=%b", rd, d, we);
            checks++;
            if ({wb_rd_wen, hold, bus_req} !== {we && rd != 5'd0, 2'b00}) begin
                errors++;
                $display("FAIL alu_wen: wen/hold/req=%b want %b", {wb_rd_wen, hold, bus_req}, {we && rd != 5'd0, 2'b00});
            end
            checks++;
            if ({wb_rd_addr, wb_rd_data} !== {rd, d}) begin
                errors++;
                $display("FAIL alu_data: rd=%0d data=%08h want rd=%0d data=%08h", wb_rd_addr, wb_rd_data, rd, d);
            end
        end
        tick();
        checks++;
        if (wb_rd_wen !== 1'b0) begin
            errors++;
            $display("FAIL alu_idle: wen=%b want 0", wb_rd_wen);
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3;
        logic [31:0] a;
        run_mem_op(1'b0, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 5'd0, 32'd0, 2, 0);
        for (int i = 0; i < 10; i++) begin
            f3 = 3'($urandom_range(0, 2));
            a  = $urandom;
            a  = a - (a % op_bytes(f3));
            run_mem_op(1'b0, f3, a, $urandom, 5'($urandom), 32'd0, $urandom_range(0, 3), 0);
        end
    endtask

    task automatic test_load();
        logic [2:0] f3s [5];
        logic [2:0] f3;
        logic [31:0] a;
        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        run_mem_op(1'b1, 3'd0, 32'h0000_2001, 32'd0, 5'd7, 32'h0000_8000, 0, 0);
        run_mem_op(1'b1, 3'd4, 32'h0000_2001, 32'd0, 5'd7, 32'h0000_8000, 0, 0);
        run_mem_op(1'b1, 3'd5, 32'h0000_2002, 32'd0, 5'd7, 32'hBEEF_0000, 1, 1);
        run_mem_op(1'b1, 3'd2, 32'h0000_2004, 32'd0, 5'd0, 32'h1234_5678, 0, 2);
        for (int i = 0; i < 14; i++) begin
            f3 = f3s[$urandom_range(0, 4)];
            a  = $urandom;
            a  = a - (a % op_bytes(f3));
            run_mem_op(1'b1, f3, a, 32'd0, 5'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_errors();
        logic [2:0]  f3;
        logic [31:0] a;
        bit          ld;
        run_mem_op(1'b1, 3'd2, 32'h0000_3002, 32'd0, 5'd9, 32'd0, 0, 0);
        run_mem_op(1'b1, 3'd3, 32'h0000_3000, 32'd0, 5'd9, 32'd0, 0, 0);
        run_mem_op(1'b0, 3'd1, 32'h0000_3001, 32'h55, 5'd0, 32'd0, 0, 0);
        run_mem_op(1'b0, 3'd4, 32'h0000_3000, 32'h55, 5'd0, 32'd0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            ld = 1'($urandom);
            f3 = 3'($urandom);
            a  = $urandom;
            run_mem_op(ld, f3, a, $urandom, 5'($urandom), $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] word, alu_d;
        word  = $urandom;
        alu_d = $urandom;
        $display("txn back_to_back lw rd=3 then alu rd=9 data=%08h", alu_d);
        op_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2;
        addr = 32'h0000_4008; rd_addr = 5'd3; rd_wen = 1'b1;
        tick();
        is_load = 1'b0; rd_addr = 5'd9; rd_data = alu_d;
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        checks++;
        if ({hold, wb_rd_wen} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_held: hold/wen=%b want 10", {hold, wb_rd_wen});
        end
        bus_rvalid = 1'b1; bus_rdata = word;
        tick();
        bus_rvalid = 1'b0;
        checks++;
        if ({hold, wb_rd_wen, wb_rd_addr, wb_rd_data} !== {2'b01, 5'd3, word}) begin
            errors++;
            $display("FAIL b2b_load: hold=%b wen=%b rd=%0d data=%08h want hold=0 wen=1 rd=3 data=%08h",
                     hold, wb_rd_wen, wb_rd_addr, wb_rd_data, word);
        end
        tick();
        clear_op();
        checks++;
        if ({hold, wb_rd_wen, wb_rd_addr, wb_rd_data} !== {2'b01, 5'd9, alu_d}) begin
            errors++;
            $display("FAIL b2b_alu: hold=%b wen=%b rd=%0d data=%08h want hold=0 wen=1 rd=9 data=%08h",
                     hold, wb_rd_wen, wb_rd_addr, wb_rd_data, alu_d);
        end
        tick();
        checks++;
        if (wb_rd_wen !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tail: wen=%b want 0", wb_rd_wen);
        end
    endtask

    task automatic test_reset_mid();
        $display("txn reset during RESP");
        op_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2;
        addr = 32'h0000_5000; rd_addr = 5'd12; rd_wen = 1'b1;
        tick();
        clear_op();
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        checks++;
        if (hold !== 1'b1) begin
            errors++;
            $display("FAIL rm_inresp: hold=%b want 1", hold);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if ({hold, bus_req, wb_rd_wen} !== 3'b000) begin
            errors++;
            $display("FAIL rm_abort: hold/req/wen=%b want 000", {hold, bus_req, wb_rd_wen});
        end
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_rvalid = 1'b0;
        checks++;
        if ({hold, wb_rd_wen, err} !== 3'b000) begin
            errors++;
            $display("FAIL rm_late_rvalid: hold/wen/err=%b want 000", {hold, wb_rd_wen, err});
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
